wb_commit: RTL and testbench

//  Writeback/commit unit directly downstream of the WB pipeline latch. Each valid

---
 rtl/wb_commit.sv | 219 +++++++++++++++++++++
 tb/tb_wb_commit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// Writeback/commit unit: drains latch stores to the D-cache, splitting page-crossing
// stores, then commits GPR/segment/EFLAGS/EIP updates in one registered cycle.
module wb_commit #(
    parameter int PA_W      = 15,
    parameter int PAGE_BITS = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_v,
    input  logic            i_wrReg1,
    input  logic            i_wrReg2,
    input  logic            i_wrSeg,
    input  logic            i_wrFlags,
    input  logic            i_wrMem1,
    input  logic            i_wrMem2,
    input  logic [31:0]     i_data1,
    input  logic [31:0]     i_data2,
    input  logic [31:0]     i_nEIP,
    input  logic [PA_W-1:0] i_PA1,
    input  logic [PA_W-1:0] i_PA2,
    input  logic [PA_W-1:0] i_PA3,
    input  logic [PA_W-1:0] i_PA4,
    input  logic [1:0]      i_size1,
    input  logic [1:0]      i_size2,
    input  logic [1:0]      i_opSize,
    input  logic [5:0]      i_eflags,
    input  logic [2:0]      i_dr1,
    input  logic [2:0]      i_dr2,
    input  logic [2:0]      i_drSeg,
    input  logic [1:0]      i_spill,
    output logic            o_stall,
    output logic            o_mreq,
    output logic [PA_W-1:0] o_maddr,
    output logic [31:0]     o_mdata,
    output logic [2:0]      o_mlen,
    input  logic            i_mack,
    output logic            o_rf_we1,
    output logic            o_rf_we2,
    output logic [2:0]      o_rf_addr1,
    output logic [2:0]      o_rf_addr2,
    output logic [31:0]     o_rf_data1,
    output logic [31:0]     o_rf_data2,
    output logic [1:0]      o_rf_size,
    output logic            o_seg_we,
    output logic [2:0]      o_seg_addr,
    output logic [15:0]     o_seg_data,
    output logic            o_flags_we,
    output logic [5:0]      o_flags,
    output logic            o_eip_we,
    output logic [31:0]     o_eip
);

    typedef enum logic [2:0] {IDLE, S1A, S1B, S2A, S2B} state_t;

    function automatic logic [2:0] nbytes(input logic [1:0] sz);
        logic [2:0] r;
        unique case (sz)
            2'b00:   r = 3'd1;
            2'b01:   r = 3'd2;
            default: r = 3'd4;
        endcase
        return r;
    endfunction

    // Bytes that fit before the page boundary, capped at the store size.
    function automatic logic [2:0] first_len(input logic [PAGE_BITS-1:0] off,
                                             input logic [2:0] b);
        logic [PAGE_BITS:0] room;
        room = (PAGE_BITS+1)'(1 << PAGE_BITS) - {1'b0, off};
        return (room < (PAGE_BITS+1)'(b)) ? room[2:0] : b;
    endfunction

    function automatic logic [31:0] lsb_bytes(input logic [31:0] d, input logic [2:0] n);
        logic [31:0] m;
        m = (n >= 3'd4) ? 32'hFFFF_FFFF : ((32'd1 << {n, 3'b000}) - 32'd1);
        return d & m;
    endfunction

    state_t          state_q, state_d;
    logic            mreq_q, mreq_d;
    logic [PA_W-1:0] maddr_q, maddr_d;
    logic [31:0]     mdata_q, mdata_d;
    logic [2:0]      mlen_q, mlen_d;
    logic            ack, last, commit;
    logic [2:0]      b1, b2, n1a, n2a;
    logic            has1b, has2b;

    assign ack   = i_mack & mreq_q;
    assign b1    = nbytes(i_size1);
    assign b2    = nbytes(i_size2);
    assign n1a   = first_len(i_PA1[PAGE_BITS-1:0], b1);
    assign n2a   = first_len(i_PA3[PAGE_BITS-1:0], b2);
    assign has1b = i_spill[0] && (n1a != b1);
    assign has2b = i_spill[1] && (n2a != b2);

    always_comb begin
        state_d = state_q;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_v && i_wrMem1)      state_d = S1A;
                else if (i_v && i_wrMem2) state_d = S2A;
            end
            S1A: if (ack) begin
                if (has1b)         state_d = S1B;
                else if (i_wrMem2) state_d = S2A;
                else begin
                    state_d = IDLE;
                    last    = 1'b1;
                end
            end
            S1B: if (ack) begin
                if (i_wrMem2) state_d = S2A;
                else begin
                    state_d = IDLE;
                    last    = 1'b1;
                end
            end
            S2A: if (ack) begin
                if (has2b) state_d = S2B;
                else begin
                    state_d = IDLE;
                    last    = 1'b1;
                end
            end
            S2B: if (ack) begin
                state_d = IDLE;
                last    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit  = (state_q == IDLE && i_v && !i_wrMem1 && !i_wrMem2) || last;
    assign o_stall = (state_q == IDLE) ? (i_v && (i_wrMem1 || i_wrMem2)) : !last;

    // Request fields follow the state being entered, so they are ready on entry.
    always_comb begin
        mreq_d  = (state_d != IDLE);
        maddr_d = '0;
        mdata_d = '0;
        mlen_d  = '0;
        unique case (state_d)
            S1A: begin
                maddr_d = i_PA1;
                mlen_d  = n1a;
                mdata_d = lsb_bytes(i_data1, n1a);
            end
            S1B: begin
                maddr_d = i_PA2;
                mlen_d  = b1 - n1a;
                mdata_d = lsb_bytes(i_data1 >> {n1a, 3'b000}, b1 - n1a);
            end
            S2A: begin
                maddr_d = i_PA3;
                mlen_d  = n2a;
                mdata_d = lsb_bytes(i_data2, n2a);
            end
            S2B: begin
                maddr_d = i_PA4;
                mlen_d  = b2 - n2a;
                mdata_d = lsb_bytes(i_data2 >> {n2a, 3'b000}, b2 - n2a);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mreq_q     <= 1'b0;
            maddr_q    <= '0;
            mdata_q    <= '0;
            mlen_q     <= '0;
            o_rf_we1   <= 1'b0;
            o_rf_we2   <= 1'b0;
            o_rf_addr1 <= '0;
            o_rf_addr2 <= '0;
            o_rf_data1 <= '0;
            o_rf_data2 <= '0;
            o_rf_size  <= '0;
            o_seg_we   <= 1'b0;
            o_seg_addr <= '0;
            o_seg_data <= '0;
            o_flags_we <= 1'b0;
            o_flags    <= '0;
            o_eip_we   <= 1'b0;
            o_eip      <= '0;
        end else begin
            state_q    <= state_d;
            mreq_q     <= mreq_d;
            maddr_q    <= maddr_d;
            mdata_q    <= mdata_d;
            mlen_q     <= mlen_d;
            o_rf_we1   <= commit && i_wrReg1;
            o_rf_we2   <= commit && i_wrReg2;
            o_seg_we   <= commit && i_wrSeg;
            o_flags_we <= commit && i_wrFlags;
            o_eip_we   <= commit;
            if (commit) begin
                o_rf_addr1 <= i_dr1;
                o_rf_addr2 <= i_dr2;
                o_rf_data1 <= i_data1;
                o_rf_data2 <= i_data2;
                o_rf_size  <= i_opSize;
                o_seg_addr <= i_drSeg;
                o_seg_data <= i_data2[15:0];
                o_flags    <= i_eflags;
                o_eip      <= i_nEIP;
            end
        end
    end

    assign o_mreq  = mreq_q;
    assign o_maddr = maddr_q;
    assign o_mdata = mdata_q;
    assign o_mlen  = mlen_q;

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed literal cases plus randomized instructions
// checked every cycle against a transaction-queue model.
module tb_wb_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_v, i_wrReg1, i_wrReg2, i_wrSeg, i_wrFlags, i_wrMem1, i_wrMem2;
    logic [31:0] i_data1, i_data2, i_nEIP;
    logic [14:0] i_PA1, i_PA2, i_PA3, i_PA4;
    logic [1:0]  i_size1, i_size2, i_opSize, i_spill;
    logic [5:0]  i_eflags;
    logic [2:0]  i_dr1, i_dr2, i_drSeg;
    logic        o_stall, o_mreq, i_mack;
    logic [14:0] o_maddr;
    logic [31:0] o_mdata;
    logic [2:0]  o_mlen;
    logic        o_rf_we1, o_rf_we2, o_seg_we, o_flags_we, o_eip_we;
    logic [2:0]  o_rf_addr1, o_rf_addr2, o_seg_addr;
    logic [31:0] o_rf_data1, o_rf_data2, o_eip;
    logic [1:0]  o_rf_size;
    logic [15:0] o_seg_data;
    logic [5:0]  o_flags;

    always #5 clk = ~clk;

    wb_commit #(.PA_W(15), .PAGE_BITS(12)) dut (
        .clk(clk), .rst(rst), .i_v(i_v),
        .i_wrReg1(i_wrReg1), .i_wrReg2(i_wrReg2), .i_wrSeg(i_wrSeg),
        .i_wrFlags(i_wrFlags), .i_wrMem1(i_wrMem1), .i_wrMem2(i_wrMem2),
        .i_data1(i_data1), .i_data2(i_data2), .i_nEIP(i_nEIP),
        .i_PA1(i_PA1), .i_PA2(i_PA2), .i_PA3(i_PA3), .i_PA4(i_PA4),
        .i_size1(i_size1), .i_size2(i_size2), .i_opSize(i_opSize),
        .i_eflags(i_eflags), .i_dr1(i_dr1), .i_dr2(i_dr2), .i_drSeg(i_drSeg),
        .i_spill(i_spill), .o_stall(o_stall), .o_mreq(o_mreq),
        .o_maddr(o_maddr), .o_mdata(o_mdata), .o_mlen(o_mlen), .i_mack(i_mack),
        .o_rf_we1(o_rf_we1), .o_rf_we2(o_rf_we2),
        .o_rf_addr1(o_rf_addr1), .o_rf_addr2(o_rf_addr2),
        .o_rf_data1(o_rf_data1), .o_rf_data2(o_rf_data2), .o_rf_size(o_rf_size),
        .o_seg_we(o_seg_we), .o_seg_addr(o_seg_addr), .o_seg_data(o_seg_data),
        .o_flags_we(o_flags_we), .o_flags(o_flags),
        .o_eip_we(o_eip_we), .o_eip(o_eip)
    );

    typedef struct {
        logic        wr1, wr2, wseg, wfl, wm1, wm2;
        logic [31:0] d1, d2, eip;
        logic [14:0] pa1, pa2, pa3, pa4;
        logic [1:0]  s1, s2, ops, sp;
        logic [5:0]  fl;
        logic [2:0]  r1, r2, sg;
    } ins_t;

    typedef struct {
        logic [14:0] a;
        logic [2:0]  l;
        logic [31:0] d;
    } tx_t;

    tx_t  txq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic ins_t blank();
        ins_t x;
        x = '{default: '0};
        return x;
    endfunction

    task automatic set_ins(input ins_t x, input logic v);
        i_v = v; i_wrReg1 = x.wr1; i_wrReg2 = x.wr2; i_wrSeg = x.wseg;
        i_wrFlags = x.wfl; i_wrMem1 = x.wm1; i_wrMem2 = x.wm2;
        i_data1 = x.d1; i_data2 = x.d2; i_nEIP = x.eip;
        i_PA1 = x.pa1; i_PA2 = x.pa2; i_PA3 = x.pa3; i_PA4 = x.pa4;
        i_size1 = x.s1; i_size2 = x.s2; i_opSize = x.ops; i_spill = x.sp;
        i_eflags = x.fl; i_dr1 = x.r1; i_dr2 = x.r2; i_drSeg = x.sg;
    endtask

    // Model: a store of B bytes at pa is cut at the 4096-byte page boundary.
    task automatic add_store(input logic [14:0] pa, input logic [14:0] pa2,
                             input logic [1:0] sz, input logic sp, input logic [31:0] d);
        int b, off, n1;
        longint unsigned dd;
        b   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(pa) % 4096;
        n1  = (4096 - off < b) ? 4096 - off : b;
        dd  = longint'(d);
        txq.push_back('{pa, 3'(n1), 32'(dd % (64'd1 << (8 * n1)))});
        if (sp && n1 < b)
            txq.push_back('{pa2, 3'(b - n1), 32'((dd >> (8 * n1)) % (64'd1 << (8 * (b - n1))))});
    endtask

    function automatic logic [14:0] rand_pa();
        logic [14:0] p;
        p = 15'($urandom);
        if ($urandom_range(0, 1) == 1) p[11:0] = 12'(4096 - $urandom_range(1, 4));
        return p;
    endfunction

    function automatic ins_t rand_ins();
        ins_t x;
        x.wr1 = 1'($urandom); x.wr2 = 1'($urandom); x.wseg = 1'($urandom);
        x.wfl = 1'($urandom); x.wm1 = 1'($urandom); x.wm2 = 1'($urandom);
        x.d1 = $urandom; x.d2 = $urandom; x.eip = $urandom;
        x.pa1 = rand_pa(); x.pa2 = 15'({x.pa1[14:12] + 3'd1, 12'd0});
        x.pa3 = rand_pa(); x.pa4 = 15'({x.pa3[14:12] + 3'd1, 12'd0});
        x.s1 = 2'($urandom); x.s2 = 2'($urandom); x.ops = 2'($urandom);
        x.sp = 2'($urandom); x.fl = 6'($urandom);
        x.r1 = 3'($urandom); x.r2 = 3'($urandom); x.sg = 3'($urandom);
        return x;
    endfunction

    task automatic check_commit(input logic v, input ins_t c);
        chk("rf_we1", o_rf_we1, v & c.wr1);
        chk("rf_we2", o_rf_we2, v & c.wr2);
        chk("seg_we", o_seg_we, v & c.wseg);
        chk("flags_we", o_flags_we, v & c.wfl);
        chk("eip_we", o_eip_we, v);
        if (v) begin
            chk("eip", o_eip, c.eip);
            chk("rf_size", o_rf_size, c.ops);
            if (c.wr1) begin
                chk("rf_addr1", o_rf_addr1, c.r1);
                chk("rf_data1", o_rf_data1, c.d1);
            end
            if (c.wr2) begin
                chk("rf_addr2", o_rf_addr2, c.r2);
                chk("rf_data2", o_rf_data2, c.d2);
            end
            if (c.wseg) begin
                chk("seg_addr", o_seg_addr, c.sg);
                chk("seg_data", o_seg_data, c.d2[15:0]);
            end
            if (c.wfl) chk("flags", o_flags, c.fl);
        end
    endtask

    ins_t x, cur, cins;
    logic busy, in_req, cv;

    initial begin
        rst = 1'b0;
        i_mack = 1'b0;
        set_ins(blank(), 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_mreq", o_mreq, 0);
        chk("rst_eip_we", o_eip_we, 0);
        chk("rst_eip", o_eip, 0);
        chk("rst_stall", o_stall, 0);
        rst = 1'b1;

        // ALU op, no stores
        @(negedge clk);
        x = blank(); x.wr1 = 1; x.r1 = 3; x.d1 = 32'h1234; x.eip = 32'h100;
        set_ins(x, 1'b1);
        #1 chk("alu_stall", o_stall, 0);
        @(negedge clk);
        set_ins(blank(), 1'b0);
        chk("alu_we1", o_rf_we1, 1);
        chk("alu_addr1", o_rf_addr1, 3);
        chk("alu_data1", o_rf_data1, 32'h1234);
        chk("alu_eip_we", o_eip_we, 1);
        chk("alu_eip", o_eip, 32'h100);
        chk("alu_mreq", o_mreq, 0);

        // 4B store, ack 2 cycles after request
        @(negedge clk);
        x = blank(); x.wm1 = 1; x.pa1 = 15'h0010; x.s1 = 2'b10;
        x.d1 = 32'hDEADBEEF; x.eip = 32'h200;
        set_ins(x, 1'b1);
        #1 chk("st_stall0", o_stall, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("st_mreq", o_mreq, 1);
            chk("st_addr", o_maddr, 15'h0010);
            chk("st_len", o_mlen, 4);
            i_mack = (k == 2);
            #1 chk("st_stall", o_stall, k != 2);
        end
        @(negedge clk);
        i_mack = 0; set_ins(blank(), 1'b0);
        chk("st_mreq_off", o_mreq, 0);
        chk("st_eip_we", o_eip_we, 1);
        chk("st_eip", o_eip, 32'h200);

        // page-crossing split store
        @(negedge clk);
        x = blank(); x.wm1 = 1; x.pa1 = 15'h0FFE; x.pa2 = 15'h1000; x.s1 = 2'b10;
        x.sp = 2'b01; x.d1 = 32'hAABBCCDD; x.eip = 32'h300;
        set_ins(x, 1'b1);
        @(negedge clk);
        chk("sp_addr1", o_maddr, 15'h0FFE);
        chk("sp_len1", o_mlen, 2);
        chk("sp_data1", o_mdata, 32'h0000CCDD);
        i_mack = 1;
        @(negedge clk);
        chk("sp_mreq2", o_mreq, 1);
        chk("sp_addr2", o_maddr, 15'h1000);
        chk("sp_len2", o_mlen, 2);
        chk("sp_data2", o_mdata, 32'h0000AABB);
        chk("sp_no_early_eip", o_eip_we, 0);
        @(negedge clk);
        i_mack = 0; set_ins(blank(), 1'b0);
        chk("sp_eip_we", o_eip_we, 1);
        chk("sp_mreq_off", o_mreq, 0);

        // spill set but store fits in page
        @(negedge clk);
        x = blank(); x.wm1 = 1; x.pa1 = 15'h0004; x.s1 = 2'b01; x.sp = 2'b01;
        x.d1 = 32'h12345678; x.eip = 32'h400;
        set_ins(x, 1'b1);
        @(negedge clk);
        chk("ns_len", o_mlen, 2);
        chk("ns_data", o_mdata, 32'h5678);
        i_mack = 1;
        #1 chk("ns_stall", o_stall, 0);
        @(negedge clk);
        i_mack = 0; set_ins(blank(), 1'b0);
        chk("ns_mreq_off", o_mreq, 0);
        chk("ns_eip_we", o_eip_we, 1);

        // reset while in the second half of a split store
        @(negedge clk);
        x = blank(); x.wm1 = 1; x.wr1 = 1; x.pa1 = 15'h0FFF; x.pa2 = 15'h1000;
        x.s1 = 2'b10; x.sp = 2'b01; x.d1 = 32'h11223344; x.eip = 32'h500;
        set_ins(x, 1'b1);
        @(negedge clk);
        i_mack = 1;
        @(negedge clk);
        i_mack = 0;
        chk("rs_in_s1b", o_maddr, 15'h1000);
        #2 rst = 1'b0;
        #1 chk("rs_mreq_drop", o_mreq, 0);
        @(negedge clk);
        set_ins(blank(), 1'b0);
        rst = 1'b1;
        chk("rs_no_we1", o_rf_we1, 0);
        chk("rs_no_eip", o_eip_we, 0);
        @(negedge clk);
        chk("rs_idle_mreq", o_mreq, 0);
        chk("rs_idle_eip", o_eip_we, 0);

        // randomized run against the queue model
        busy = 0; in_req = 0; cv = 0; cins = blank();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("mreq", o_mreq, in_req);
            if (in_req) begin
                chk("maddr", o_maddr, txq[0].a);
                chk("mlen", o_mlen, txq[0].l);
                chk("mdata", o_mdata, txq[0].d);
            end
            check_commit(cv, cins);
            cv = 0;
            if (!busy) begin
                cur = rand_ins();
                if ($urandom_range(0, 3) != 0) begin
                    set_ins(cur, 1'b1);
                    busy = 1;
                    txq.delete();
                    if (cur.wm1) add_store(cur.pa1, cur.pa2, cur.s1, cur.sp[0], cur.d1);
                    if (cur.wm2) add_store(cur.pa3, cur.pa4, cur.s2, cur.sp[1], cur.d2);
                end else begin
                    set_ins(cur, 1'b0);
                end
            end
            i_mack = 1'($urandom);
            #1 chk("stall", o_stall,
                   busy && txq.size() > 0 && !(in_req && i_mack && txq.size() == 1));
            if (busy) begin
                if (txq.size() == 0) begin
                    cv = 1; cins = cur; busy = 0;
                end else if (!in_req) begin
                    in_req = 1;
                end else if (i_mack) begin
                    void'(txq.pop_front());
                    if (txq.size() == 0) begin
                        in_req = 0; cv = 1; cins = cur; busy = 0;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
